digit_serial_addsub: RTL and testbench
======================================

# digit_serial_addsub

Parametrised, multi-cycle add/subtract unit that processes `DIGIT` bits per clock, LSB first, under a start/rdy/done handshake. It generalises the fixed 8-bit subtract-and-complement datapath to arbitrary width, adds an add mode, and optionally returns the magnitude of a negative difference. It uses a separate controller FSM and datapath, and is used wherever area matters more than latency.

## Interface
- `WIDTH`, default 8: operand and result width; must be ≥ 2.
- `DIGIT`, default 1: bits processed per RUN cycle; `WIDTH % DIGIT == 0` is required (elaboration assertion); `N = WIDTH/DIGIT`.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst_b`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only while `rdy`=1.
- `op`  in  1  0 = add (A+B), 1 = subtract (A−B); sampled with `start`.
- `abs_mode`  in  1  1 = return |A−B| when the difference is negative; sampled with `start`; ignored when `op`=0.
- `A`, `B`  in  WIDTH  unsigned operands; sampled with `start`.
- `result`  out  WIDTH  registered result.
- `co`  out  1  final adder carry (add: carry-out; sub: 1 = A ≥ B).
- `neg`  out  1  `op & ~co`: subtraction borrowed.
- `zero`  out  1  `result == 0`, registered with `result`.
- `rdy`  out  1  high in IDLE (decoded from state).
- `done`  out  1  one-cycle pulse when `result` and the flags become valid.

## Operation
- FSM states: S_IDLE, S_RUN, S_COMP. Reset state is S_IDLE.
- S_IDLE: `rdy`=1. If `start`=1 at the edge, latch A, B, `op` and `abs_mode`; clear the digit counter; set the carry flop to `op`; go to S_RUN. Otherwise stay.
- S_RUN: each cycle computes `{c, d} = A[DIGIT-1:0] + (op ? ~B[DIGIT-1:0] : B[DIGIT-1:0]) + carry`.
  - Shift A and B right by DIGIT.
  - Shift `d` into the result register from the top.
  - Increment the counter.
- On the Nth RUN cycle:
  - If `op & abs_mode & ~c`, go to S_COMP.
  - Otherwise go to S_IDLE and pulse `done`.
- S_COMP: one cycle; `result <= ~result + 1` (mod 2^WIDTH); go to S_IDLE and pulse `done`.
- Flags: `co` and `neg` update after the final RUN cycle. `zero` updates with every `result` write and is only meaningful once `done` has pulsed.
- `result`, `co`, `neg` and `zero` hold their values until the next accepted `start`. During RUN they are intermediate and not valid.
- All arithmetic wraps modulo 2^WIDTH. Add overflow is reported only through `co`.

## Timing
- Reset (asynchronous, any state): state = S_IDLE, `result`=0, `co`=0, `neg`=0, `zero`=1, `done`=0, `rdy`=1. An in-flight operation is discarded and no `done` is produced.
- Latency, counted from the edge that samples `start`:
  - `done` is high in cycle N+1 when no complement is needed.
  - `done` is high in cycle N+2 with a complement.
- `rdy` falls the cycle after `start` is accepted and is high again in the cycle where `done` is high.
- Back-to-back operation: `start` asserted during the `done` cycle is accepted. The new operation starts and `done` deasserts the next cycle.
- `start` while `rdy`=0 is ignored; it is neither queued nor able to corrupt the operation.
- Operand and mode changes after acceptance have no effect.
- The `done` pulse is exactly one cycle wide. It never asserts without a preceding accepted `start`.

## Test plan
- W=8, D=1; sub, abs=1, A=200, B=55 → `result`=145, `neg`=0, `co`=1; `done` high in cycle 9.
- W=8, D=1; sub, A=55, B=200:
  - abs=1 → `result`=145, `neg`=1, `done` in cycle 10.
  - abs=0 → `result`=0x6F, `neg`=1, `done` in cycle 9.
- W=8, D=4; add, A=200, B=100 → `result`=44, `co`=1, `neg`=0, `done` in cycle 3. Then sub 0x5A−0x5A → `result`=0, `zero`=1, `co`=1, `neg`=0.
- W=16, D=2; sub, abs=1, A=0x0001, B=0xFFFF → `result`=0xFFFE, `neg`=1, `done` in cycle 10.
- Handshake:
  - `start` pulsed mid-RUN with new operands → ignored; the original result is produced.
  - `start` held high through `done` → second operation accepted; exactly one `done` per operation.
- Reset: drop `rst_b` in RUN cycle 4 → immediately `rdy`=1, `result`=0, `done`=0. After release, a new operation completes correctly.

Source files
------------

// File: rtl/digit_serial_addsub.sv
// Digit-serial unsigned add/subtract: DIGIT bits per cycle, LSB first, with an
// optional two's-complement pass that turns a negative difference into |A-B|.
module digit_serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic             op,
  input  logic             abs_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             co,
  output logic             neg,
  output logic             zero,
  output logic             rdy,
  output logic             done,
  output logic [1:0]       fsm_state
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("digit_serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_COMP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]       a_sh, b_sh;
  logic                   op_q, abs_q, carry;
  logic [CW-1:0]          cnt;
  logic [DIGIT-1:0]       b_dig;
  logic [DIGIT:0]         dsum;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0]       res_shift;
  logic [WIDTH-1:0]       res_comp;
  logic                   last, need_comp, done_nxt;

  // Subtraction is A + ~B + 1; the +1 comes from the carry flop preset to op.
  always_comb begin
    b_dig     = op_q ? ~b_sh[DIGIT-1:0] : b_sh[DIGIT-1:0];
    dsum      = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry};
    res_cat   = {dsum[DIGIT-1:0], result};
    res_shift = res_cat[WIDTH+DIGIT-1:DIGIT];
    res_comp  = ~result + WIDTH'(1);
    last      = (cnt == CW'(N - 1));
    need_comp = op_q & abs_q & ~dsum[DIGIT];
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN: begin
        if (last) begin
          if (need_comp) begin
            state_nxt = S_COMP;
          end else begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      S_COMP: begin
        state_nxt = S_IDLE;
        done_nxt  = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= S_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      a_sh   <= '0;
      b_sh   <= '0;
      op_q   <= 1'b0;
      abs_q  <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      co     <= 1'b0;
      neg    <= 1'b0;
      zero   <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh  <= A;
            b_sh  <= B;
            op_q  <= op;
            abs_q <= abs_mode;
            carry <= op;
            cnt   <= '0;
          end
        end
        S_RUN: begin
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          carry  <= dsum[DIGIT];
          result <= res_shift;
          zero   <= (res_shift == '0);
          cnt    <= cnt + CW'(1);
          if (last) begin
            co  <= dsum[DIGIT];
            neg <= op_q & ~dsum[DIGIT];
          end
        end
        S_COMP: begin
          result <= res_comp;
          zero   <= (res_comp == '0);
        end
        default: ;
      endcase
    end
  end

  assign rdy       = (state == S_IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Bench for digit_serial_addsub: three configurations (8/1, 8/4, 16/2) checked
// against an arithmetic reference model through per-instance expected queues.
module tb_digit_serial_addsub;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  logic        start_v [3];
  logic        op_v    [3];
  logic        abs_v   [3];
  logic [15:0] a_v     [3];
  logic [15:0] b_v     [3];
  logic [2:0]  co_v, neg_v, zero_v, rdy_v, done_v;
  logic [7:0]  r0, r1;
  logic [15:0] r2;
  logic [1:0]  st0, st1, st2;

  digit_serial_addsub #(.WIDTH(8), .DIGIT(1)) u0 (
    .clk(clk), .rst_b(rst_b), .start(start_v[0]), .op(op_v[0]), .abs_mode(abs_v[0]),
    .A(a_v[0][7:0]), .B(b_v[0][7:0]), .result(r0), .co(co_v[0]), .neg(neg_v[0]),
    .zero(zero_v[0]), .rdy(rdy_v[0]), .done(done_v[0]), .fsm_state(st0));

  digit_serial_addsub #(.WIDTH(8), .DIGIT(4)) u1 (
    .clk(clk), .rst_b(rst_b), .start(start_v[1]), .op(op_v[1]), .abs_mode(abs_v[1]),
    .A(a_v[1][7:0]), .B(b_v[1][7:0]), .result(r1), .co(co_v[1]), .neg(neg_v[1]),
    .zero(zero_v[1]), .rdy(rdy_v[1]), .done(done_v[1]), .fsm_state(st1));

  digit_serial_addsub #(.WIDTH(16), .DIGIT(2)) u2 (
    .clk(clk), .rst_b(rst_b), .start(start_v[2]), .op(op_v[2]), .abs_mode(abs_v[2]),
    .A(a_v[2]), .B(b_v[2]), .result(r2), .co(co_v[2]), .neg(neg_v[2]),
    .zero(zero_v[2]), .rdy(rdy_v[2]), .done(done_v[2]), .fsm_state(st2));

  int tests = 0;
  int fails = 0;
  int done_cnt [3];
  logic prev_done [3];

  // Expected entry: {zero, neg, co, result[15:0]}
  logic [18:0] q0[$], q1[$], q2[$];

  function automatic int wid(input int sel);
    return (sel == 2) ? 16 : 8;
  endfunction

  function automatic int dig(input int sel);
    return (sel == 0) ? 1 : ((sel == 1) ? 4 : 2);
  endfunction

  function automatic logic [15:0] res_of(input int sel);
    case (sel)
      0:       return {8'h00, r0};
      1:       return {8'h00, r1};
      default: return r2;
    endcase
  endfunction

  function automatic void push_exp(input int sel, input logic [18:0] e);
    case (sel)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic int qsize(input int sel);
    case (sel)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [18:0] pop_exp(input int sel);
    case (sel)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Reference: plain unsigned arithmetic on the whole word.
  function automatic void model(input int sel, input logic op, input logic absm,
                                input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic co, output logic neg,
                                output int lat);
    longint m, s, av, bv;
    int w;
    w  = wid(sel);
    m  = (longint'(1) << w) - 1;
    av = longint'(a) & m;
    bv = longint'(b) & m;
    s  = op ? (av + ((~bv) & m) + 1) : (av + bv);
    co = ((s >> w) & 1) != 0;
    neg = op && !co;
    r  = 16'(s & m);
    if (neg && absm) r = 16'(bv - av);
    lat = w / dig(sel) + 1 + ((neg && absm) ? 1 : 0);
  endfunction

  function automatic logic [18:0] pack_exp(input logic [15:0] r, input logic co, input logic neg);
    return {(r == 16'h0000), neg, co, r};
  endfunction

  always @(negedge clk) begin
    logic [18:0] got, e;
    for (int i = 0; i < 3; i++) begin
      if (done_v[i]) begin
        tests++;
        got = {zero_v[i], neg_v[i], co_v[i], res_of(i)};
        if (qsize(i) == 0) begin
          fails++;
          $display("FAIL done_spurious inst%0d: done with no accepted op, got %h", i, got);
        end else begin
          e = pop_exp(i);
          if (got !== e || prev_done[i]) begin
            fails++;
            $display("FAIL done_result inst%0d: got zero/neg/co/res=%b/%b/%b/%h wide=%b, expected %b/%b/%b/%h",
                     i, got[18], got[17], got[16], got[15:0], prev_done[i], e[18], e[17], e[16], e[15:0]);
          end
        end
        done_cnt[i]++;
      end
      prev_done[i] = done_v[i];
    end
  end

  task automatic run_op(input int sel, input logic op, input logic absm,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] er, input logic eco, input logic eneg,
                        input int elat, input int poke, input string name);
    logic [15:0] mr;
    logic mco, mneg;
    int mlat, cyc;
    model(sel, op, absm, a, b, mr, mco, mneg, mlat);
    tests++;
    if (mr !== er || mco !== eco || mneg !== eneg || mlat != elat) begin
      fails++;
      $display("FAIL model_%s: model res/co/neg/lat=%h/%b/%b/%0d, hand value %h/%b/%b/%0d",
               name, mr, mco, mneg, mlat, er, eco, eneg, elat);
    end
    @(negedge clk);
    cyc = 0;
    while (!rdy_v[sel] && cyc < 40) begin @(negedge clk); cyc++; end
    a_v[sel] = a; b_v[sel] = b; op_v[sel] = op; abs_v[sel] = absm;
    start_v[sel] = 1'b1;
    @(posedge clk);
    push_exp(sel, pack_exp(mr, mco, mneg));
    #1;
    start_v[sel] = 1'b0;
    a_v[sel] = 16'($urandom_range(0, 65535));
    b_v[sel] = 16'($urandom_range(0, 65535));
    op_v[sel] = ~op; abs_v[sel] = ~absm;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        tests++;
        if (rdy_v[sel] !== 1'b0) begin
          fails++;
          $display("FAIL rdy_fall_%s: rdy=%b in cycle 1, expected 0", name, rdy_v[sel]);
        end
      end
      if (poke != 0 && cyc == poke) start_v[sel] = 1'b1;
      if (poke != 0 && cyc == poke + 1) start_v[sel] = 1'b0;
    end while (!done_v[sel] && cyc < 40);
    start_v[sel] = 1'b0;
    tests++;
    if (!done_v[sel] || cyc != elat || rdy_v[sel] !== 1'b1) begin
      fails++;
      $display("FAIL latency_%s: done=%b rdy=%b at cycle %0d, expected done=1 rdy=1 at cycle %0d",
               name, done_v[sel], rdy_v[sel], cyc, elat);
    end
  endtask

  initial begin
    logic [15:0] mr;
    logic mco, mneg;
    int mlat, cyc, dc;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0; op_v[i] = 1'b0; abs_v[i] = 1'b0;
      a_v[i] = 16'h0; b_v[i] = 16'h0; done_cnt[i] = 0; prev_done[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (res_of(i) !== 16'h0 || co_v[i] !== 1'b0 || neg_v[i] !== 1'b0 || zero_v[i] !== 1'b1 ||
          rdy_v[i] !== 1'b1 || done_v[i] !== 1'b0) begin
        fails++;
        $display("FAIL reset_state inst%0d: res=%h co=%b neg=%b zero=%b rdy=%b done=%b, expected 0/0/0/1/1/0",
                 i, res_of(i), co_v[i], neg_v[i], zero_v[i], rdy_v[i], done_v[i]);
      end
    end
    rst_b = 1'b1;

    run_op(0, 1, 1, 16'd200, 16'd55,  16'd145,  1, 0, 9,  0, "sub_abs_pos");
    run_op(0, 1, 1, 16'd55,  16'd200, 16'd145,  0, 1, 10, 0, "sub_abs_neg");
    run_op(0, 1, 0, 16'd55,  16'd200, 16'h006F, 0, 1, 9,  0, "sub_raw_neg");
    run_op(0, 0, 0, 16'd255, 16'd1,   16'd0,    1, 0, 9,  0, "add_wrap");
    run_op(0, 1, 0, 16'd100, 16'd37,  16'd63,   1, 0, 9,  3, "mid_run_poke");
    run_op(1, 0, 0, 16'd200, 16'd100, 16'd44,   1, 0, 3,  0, "d4_add");
    run_op(1, 1, 0, 16'h5A,  16'h5A,  16'd0,    1, 0, 3,  0, "d4_sub_eq");
    run_op(1, 0, 1, 16'd10,  16'd20,  16'd30,   0, 0, 3,  0, "d4_add_abs_ignored");
    run_op(1, 1, 1, 16'd3,   16'd5,   16'd2,    0, 1, 4,  0, "d4_sub_abs");
    run_op(2, 1, 1, 16'h0001, 16'hFFFF, 16'hFFFE, 0, 1, 10, 0, "w16_sub_abs");
    run_op(2, 0, 0, 16'h1234, 16'h4321, 16'h5555, 0, 0, 9,  0, "w16_add");
    run_op(2, 0, 0, 16'hFFFF, 16'h0001, 16'h0000, 1, 0, 9,  4, "w16_add_wrap_poke");

    // start held high across done: the second operation is taken in the done cycle
    @(negedge clk);
    dc = done_cnt[1];
    a_v[1] = 16'd200; b_v[1] = 16'd100; op_v[1] = 1'b0; abs_v[1] = 1'b0;
    start_v[1] = 1'b1;
    @(posedge clk);
    model(1, 1'b0, 1'b0, 16'd200, 16'd100, mr, mco, mneg, mlat);
    push_exp(1, pack_exp(mr, mco, mneg));
    #1;
    a_v[1] = 16'd3; b_v[1] = 16'd5; op_v[1] = 1'b1; abs_v[1] = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!done_v[1] && cyc < 40);
    tests++;
    if (!done_v[1] || cyc != 3) begin
      fails++;
      $display("FAIL hold_first_latency: done=%b at cycle %0d, expected done=1 at cycle 3", done_v[1], cyc);
    end
    @(posedge clk);
    model(1, 1'b1, 1'b1, 16'd3, 16'd5, mr, mco, mneg, mlat);
    push_exp(1, pack_exp(mr, mco, mneg));
    #1;
    start_v[1] = 1'b0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!done_v[1] && cyc < 40);
    tests++;
    if (!done_v[1] || cyc != 4) begin
      fails++;
      $display("FAIL hold_second_latency: done=%b at cycle %0d, expected done=1 at cycle 4", done_v[1], cyc);
    end
    repeat (4) @(negedge clk);
    tests++;
    if (done_cnt[1] - dc != 2) begin
      fails++;
      $display("FAIL hold_done_count: %0d done pulses, expected 2", done_cnt[1] - dc);
    end

    // reset in RUN cycle 4 discards the operation
    @(negedge clk);
    dc = done_cnt[0];
    a_v[0] = 16'd200; b_v[0] = 16'd55; op_v[0] = 1'b1; abs_v[0] = 1'b1;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst_b = 1'b0;
    #1;
    tests++;
    if (rdy_v[0] !== 1'b1 || res_of(0) !== 16'h0 || done_v[0] !== 1'b0 || zero_v[0] !== 1'b1 ||
        co_v[0] !== 1'b0 || neg_v[0] !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_run: rdy=%b res=%h done=%b zero=%b co=%b neg=%b, expected 1/0/0/1/0/0",
               rdy_v[0], res_of(0), done_v[0], zero_v[0], co_v[0], neg_v[0]);
    end
    @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    repeat (12) @(negedge clk);
    tests++;
    if (done_cnt[0] != dc) begin
      fails++;
      $display("FAIL reset_no_done: %0d done pulses after reset, expected 0", done_cnt[0] - dc);
    end
    run_op(0, 1, 1, 16'd55, 16'd200, 16'd145, 0, 1, 10, 0, "after_reset");

    repeat (4) @(negedge clk);
    tests++;
    if (qsize(0) != 0 || qsize(1) != 0 || qsize(2) != 0) begin
      fails++;
      $display("FAIL queue_drain: pending %0d/%0d/%0d, expected 0/0/0", qsize(0), qsize(1), qsize(2));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
